store_port: RTL and testbench

STORE_PORT -- requirements
Module: store_port

---
 rtl/store_port_pkg.sv | 26 ++
 rtl/store_port_fifo.sv | 63 ++++++
 rtl/store_port.sv | 111 +++++++++++
 tb/tb_store_port.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_port_pkg.sv
// Shared types for the store port: address/data/mask words,
// the buffered store entry and the write-FSM state encoding.
package store_port_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] xlen_t;
  typedef logic [3:0]  mask_t;

  typedef struct packed {
    addr_t addr;
    xlen_t data;
    mask_t mask;
  } st_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } st_state_e;

  function automatic addr_t word_align(addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_port_fifo.sv
// Store request FIFO: circular buffer with registered occupancy,
// pointers wrap modulo DEPTH (power of two).
module store_fifo
  import store_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  st_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output st_entry_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  st_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // next pointers and occupancy; push+pop leaves count unchanged
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // pointer/occupancy registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/store_port.sv
// Store port: buffers SQ stores and writes them to memory one at a
// time, retrying bus errors up to MAX_RETRY before flagging a fault.
module store_port
  import store_port_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  store_valid,
  input  addr_t store_addr,
  input  xlen_t store_data,
  input  mask_t store_mask,
  output logic  store_avail,
  output logic  store_accepted,
  output logic  mem_req_valid,
  input  logic  mem_req_ready,
  output addr_t mem_addr,
  output xlen_t mem_wdata,
  output mask_t mem_wmask,
  input  logic  mem_resp_valid,
  input  logic  mem_resp_err,
  output logic  fault
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  st_state_e     state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fault_q, fault_d;
  logic          req, acc;
  logic          full, empty;
  st_entry_t     head, push_data;

  assign push_data = '{addr: store_addr, data: store_data,
                       mask: store_mask};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (store_valid && store_avail),
    .push_data_i (push_data),
    .pop_i       (acc),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign store_avail    = !full;
  assign mem_addr       = word_align(head.addr);
  assign mem_wdata      = head.data;
  assign mem_wmask      = head.mask;
  assign mem_req_valid  = req && !reset;
  assign store_accepted = acc && !reset;
  assign fault          = fault_q && !reset;

  // write FSM: next state, retry bookkeeping and handshake outputs
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fault_d = fault_q;
    req     = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = (head.mask != '0) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (!mem_resp_err) begin
            retry_d = '0;
            state_d = ST_DONE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_REQ;
          end else begin
            retry_d = '0;
            fault_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        acc     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, retry counter and sticky fault registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_store_port.sv
// Scoreboard bench for store_port: directed scenarios followed by
// randomized traffic against a transaction-level model.
module tb_store_port;

  localparam int DEPTH = 2;
  localparam int MAXR  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        store_valid = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  store_mask = '0;
  logic        store_avail, store_accepted;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_err = 1'b0;
  logic        fault;

  store_port #(.DEPTH(DEPTH), .MAX_RETRY(MAXR)) dut (
    .clock          (clock),
    .reset          (reset),
    .store_valid    (store_valid),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .store_mask     (store_mask),
    .store_avail    (store_avail),
    .store_accepted (store_accepted),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_err   (mem_resp_err),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  st_t exp_q[$];
  int  reqs = 0, errs = 0;
  bit  waiting = 0, fault_exp = 0;
  int  n_acc = 0, n_enq = 0, n_drop = 0, n_req = 0;
  int  hs_cnt = 0;
  logic [31:0] last_addr = '0;
  bit  err_plan[$];
  int  err_rate = 0;
  int  ready_mode = 1;
  bit  hold_resp = 0, inject_late = 0, noise = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected/not reached", nm);
  endtask

  // monitor: compares DUT outputs with the transaction model
  initial begin
    st_t h;
    int  er;
    bit  pv, pr;
    pv = 0;
    pr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req", mem_req_valid, 0);
        chk("rst_acc", store_accepted, 0);
        chk("rst_fault", fault, 0);
        n_drop += exp_q.size();
        exp_q.delete();
        waiting = 0; reqs = 0; errs = 0;
        fault_exp = 0; pv = 0; pr = 0;
      end else begin
        chk("fault", fault, fault_exp);
        chk("store_avail", store_avail, exp_q.size() < DEPTH);
        if (pv && !pr) chk("req_hold", mem_req_valid, 1);
        if (mem_resp_valid && waiting) begin
          waiting = 0;
          if (mem_resp_err) begin
            errs++;
            if (errs > MAXR) fault_exp = 1;
          end
        end
        if (mem_req_valid) begin
          if (exp_q.size() == 0) fail("req_without_store");
          else begin
            h = exp_q[0];
            if (h.m == 4'b0) fail("req_on_zero_mask");
            chk("mem_addr", mem_addr, h.a & 32'hFFFF_FFFC);
            chk("mem_wdata", mem_wdata, h.d);
            chk("mem_wmask", mem_wmask, h.m);
            if (mem_req_ready) begin
              reqs++; n_req++;
              waiting = 1;
              hs_cnt++;
              last_addr = mem_addr;
            end
          end
        end
        pv = mem_req_valid;
        pr = mem_req_ready;
        if (store_accepted) begin
          if (exp_q.size() == 0) fail("accept_without_store");
          else begin
            h = exp_q.pop_front();
            if (h.m == 4'b0) er = 0;
            else er = (errs > MAXR) ? errs : errs + 1;
            chk("req_count", reqs, er);
            chk("accept_while_waiting", waiting, 0);
            n_acc++;
            reqs = 0; errs = 0;
          end
        end
        if (store_valid && store_avail) begin
          exp_q.push_back('{a: store_addr, d: store_data,
                            m: store_mask});
          n_enq++;
        end
      end
    end
  end

  // memory responder: ready policy, delayed responses, errors, noise
  initial begin
    int taken, dly;
    taken = 0;
    dly = 0;
    forever begin
      @(posedge clock);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      case (ready_mode)
        0: mem_req_ready = 1'b0;
        1: mem_req_ready = 1'b1;
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset) taken = hs_cnt;
      if (taken != hs_cnt && !hold_resp && !reset) begin
        if (dly > 0) dly--;
        else begin
          mem_resp_valid = 1'b1;
          if (err_plan.size() > 0) mem_resp_err = err_plan.pop_front();
          else mem_resp_err = ($urandom_range(0, 99) < err_rate);
          taken++;
          dly = $urandom_range(0, 2);
        end
      end else if (inject_late) begin
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'($urandom_range(0, 1));
      end else if (noise && taken == hs_cnt) begin
        mem_resp_valid = ($urandom_range(0, 9) == 0);
        mem_resp_err   = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(logic [31:0] a, logic [31:0] d,
                      logic [3:0] m);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_mask  = m;
    cyc(1);
    store_valid = 1'b0;
  endtask

  task automatic send_wait(logic [31:0] a, logic [31:0] d,
                           logic [3:0] m);
    int k;
    k = 0;
    while (!store_avail && k < 200) begin
      cyc(1);
      k++;
    end
    if (k >= 200) fail("avail_timeout");
    send(a, d, m);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || waiting) && k < 1000) begin
      cyc(1);
      k++;
    end
    if (k >= 1000) fail("drain_timeout");
    cyc(2);
  endtask

  // stimulus: directed scenarios, then random traffic
  initial begin
    int a0, r0, k;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // single partial store
    ready_mode = 1; err_rate = 0;
    a0 = n_acc;
    send_wait(32'h1003, 32'hAABBCCDD, 4'b1000);
    wait_idle();
    chk("t1_addr", last_addr, 32'h1000);
    chk("t1_acc", n_acc - a0, 1);

    // fill with memory stalled, third store ignored
    ready_mode = 0;
    a0 = n_acc;
    send(32'h2000, 32'h1111_1111, 4'b1111);
    send(32'h2004, 32'h2222_2222, 4'b0011);
    send(32'h2008, 32'h3333_3333, 4'b1100);
    chk("t2_full", store_avail, 0);
    cyc(3);
    ready_mode = 1;
    wait_idle();
    chk("t2_acc", n_acc - a0, 2);

    // zero mask: no bus access
    a0 = n_acc; r0 = n_req;
    send_wait(32'h3000, 32'h5555_5555, 4'b0000);
    wait_idle();
    chk("t3_acc", n_acc - a0, 1);
    chk("t3_reqs", n_req - r0, 0);

    // two errors then OK
    a0 = n_acc; r0 = n_req;
    err_plan.push_back(1); err_plan.push_back(1);
    err_plan.push_back(0);
    send_wait(32'h4002, 32'hDEAD_BEEF, 4'b0110);
    wait_idle();
    chk("t4_acc", n_acc - a0, 1);
    chk("t4_reqs", n_req - r0, 3);
    chk("t4_fault", fault, 0);

    // retries exhausted, then next store still drains
    a0 = n_acc;
    for (int i = 0; i < 4; i++) err_plan.push_back(1);
    send_wait(32'h5000, 32'h0BAD_F00D, 4'b1111);
    wait_idle();
    chk("t5_fault", fault, 1);
    chk("t5_acc", n_acc - a0, 1);
    send_wait(32'h5004, 32'h600D_600D, 4'b0001);
    wait_idle();
    chk("t5_acc2", n_acc - a0, 2);
    chk("t5_fault_sticky", fault, 1);

    // reset while waiting for a response, then a late response
    hold_resp = 1;
    send_wait(32'h6000, 32'h7777_7777, 4'b1111);
    k = 0;
    while (!waiting && k < 50) begin
      cyc(1);
      k++;
    end
    if (k >= 50) fail("t6_wait_timeout");
    cyc(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    hold_resp = 0;
    a0 = n_acc; r0 = n_req;
    inject_late = 1;
    cyc(1);
    inject_late = 0;
    cyc(5);
    chk("t6_acc", n_acc - a0, 0);
    chk("t6_reqs", n_req - r0, 0);
    chk("t6_avail", store_avail, 1);
    chk("t6_fault", fault, 0);

    // randomized traffic
    ready_mode = 2; err_rate = 30; noise = 1;
    for (int i = 0; i < 1500; i++) begin
      store_valid = 1'($urandom_range(0, 1));
      store_addr  = $urandom;
      store_data  = $urandom;
      store_mask  = ($urandom_range(0, 7) == 0) ? 4'b0 :
                    4'($urandom_range(0, 15));
      cyc(1);
    end
    store_valid = 1'b0;
    noise = 0;
    wait_idle();
    chk("end_empty", exp_q.size(), 0);
    chk("end_acc_total", n_acc, n_enq - n_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
